// File: rtl/traffic_phase_scheduler.sv
// Two-way intersection phase scheduler with a pedestrian all-red walk phase.
// Sequences green/yellow/all-red/walk phases paced by the ce tick, rests in
// green while the cross direction and pedestrians are idle, and decodes the
// lamps, countdown displays and walk signal from the registered state only.
module traffic_phase_scheduler #(
  parameter int YELLOW_TIME  = 3,
  parameter int ALL_RED_TIME = 1,
  parameter int WALK_TIME    = 8,
  parameter int MIN_GREEN    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic [5:0] green_time,
  input  logic       ns_sense,
  input  logic       ew_sense,
  input  logic       ped_req,
  output logic [5:0] lights,
  output logic [6:0] time_left_ns,
  output logic [6:0] time_left_ew,
  output logic       ped_walk
);

  typedef enum logic [2:0] {
    NS_G,
    NS_Y,
    EW_G,
    EW_Y,
    ALL_RED,
    WALK
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] tmr_q, tmr_d;
  logic       next_dir_q, next_dir_d;
  logic       ped_pending_q, ped_pending_d;
  logic       pend;
  logic [6:0] green_dur;

  assign pend      = ped_pending_q | ped_req;
  assign green_dur = (green_time < 6'(MIN_GREEN)) ? 7'(MIN_GREEN) : {1'b0, green_time};

  // State, countdown, direction and pedestrian latch registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ALL_RED;
      tmr_q         <= 7'(ALL_RED_TIME);
      next_dir_q    <= 1'b0;
      ped_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      next_dir_q    <= next_dir_d;
      ped_pending_q <= ped_pending_d;
    end
  end

  // Tick countdown and phase sequencing; the pedestrian latch ignores ce.
  always_comb begin
    state_d       = state_q;
    tmr_d         = tmr_q;
    next_dir_d    = next_dir_q;
    ped_pending_d = pend;
    if (ce) begin
      if (tmr_q > 7'd1) begin
        tmr_d = tmr_q - 7'd1;
      end else begin
        unique case (state_q)
          NS_G: begin
            if (ew_sense || pend) begin
              state_d = NS_Y;
              tmr_d   = 7'(YELLOW_TIME);
            end else begin
              tmr_d = 7'd1;
            end
          end
          EW_G: begin
            if (ns_sense || pend) begin
              state_d = EW_Y;
              tmr_d   = 7'(YELLOW_TIME);
            end else begin
              tmr_d = 7'd1;
            end
          end
          NS_Y: begin
            state_d    = ALL_RED;
            tmr_d      = 7'(ALL_RED_TIME);
            next_dir_d = 1'b1;
          end
          EW_Y: begin
            state_d    = ALL_RED;
            tmr_d      = 7'(ALL_RED_TIME);
            next_dir_d = 1'b0;
          end
          ALL_RED: begin
            if (pend) begin
              // Entering WALK serves the request, including one arriving now.
              state_d       = WALK;
              tmr_d         = 7'(WALK_TIME);
              ped_pending_d = 1'b0;
            end else begin
              state_d = next_dir_q ? EW_G : NS_G;
              tmr_d   = green_dur;
            end
          end
          WALK: begin
            state_d = next_dir_q ? EW_G : NS_G;
            tmr_d   = green_dur;
          end
          default: begin
            state_d = ALL_RED;
            tmr_d   = 7'(ALL_RED_TIME);
          end
        endcase
      end
    end
  end

  // Lamp, countdown and walk decode from registered state only.
  always_comb begin
    lights       = 6'b100100;
    time_left_ns = '0;
    time_left_ew = '0;
    ped_walk     = 1'b0;
    unique case (state_q)
      NS_G: begin
        lights       = 6'b001100;
        time_left_ns = tmr_q;
      end
      NS_Y: begin
        lights       = 6'b010100;
        time_left_ns = tmr_q;
      end
      EW_G: begin
        lights       = 6'b100001;
        time_left_ew = tmr_q;
      end
      EW_Y: begin
        lights       = 6'b100010;
        time_left_ew = tmr_q;
      end
      WALK:    ped_walk = 1'b1;
      default: lights   = 6'b100100;
    endcase
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench for traffic_phase_scheduler: a table of the basic
// cycle, hand-written corner sequences, and randomized traffic compared
// every cycle against a phase-level reference model.
module tb_traffic_phase_scheduler;

  localparam int YT  = 3;
  localparam int ART = 1;
  localparam int WT  = 8;
  localparam int MG  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic [5:0] green_time;
  logic       ns_sense;
  logic       ew_sense;
  logic       ped_req;
  logic [5:0] lights;
  logic [6:0] time_left_ns;
  logic [6:0] time_left_ew;
  logic       ped_walk;

  traffic_phase_scheduler #(
    .YELLOW_TIME (YT),
    .ALL_RED_TIME(ART),
    .WALK_TIME   (WT),
    .MIN_GREEN   (MG)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .green_time  (green_time),
    .ns_sense    (ns_sense),
    .ew_sense    (ew_sense),
    .ped_req     (ped_req),
    .lights      (lights),
    .time_left_ns(time_left_ns),
    .time_left_ew(time_left_ew),
    .ped_walk    (ped_walk)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model (phase level) ----------------
  typedef enum int {PH_NSG, PH_NSY, PH_EWG, PH_EWY, PH_CLR, PH_WALK} phase_t;
  phase_t m_ph;
  int     m_left;
  bit     m_dir_ew;
  bit     m_ped;

  function automatic logic [5:0] lamp_of(phase_t p);
    case (p)
      PH_NSG:  return 6'b001100;
      PH_NSY:  return 6'b010100;
      PH_EWG:  return 6'b100001;
      PH_EWY:  return 6'b100010;
      default: return 6'b100100;
    endcase
  endfunction

  function automatic int len_of(phase_t p, int g);
    case (p)
      PH_NSG, PH_EWG: return (g < MG) ? MG : g;
      PH_NSY, PH_EWY: return YT;
      PH_CLR:         return ART;
      default:        return WT;
    endcase
  endfunction

  task automatic model_reset();
    m_ph = PH_CLR; m_left = ART; m_dir_ew = 1'b0; m_ped = 1'b0;
  endtask

  task automatic enter(phase_t p);
    m_ph   = p;
    m_left = len_of(p, int'(green_time));
  endtask

  // One clock edge of the intended behaviour, using the inputs present at it.
  task automatic model_edge();
    bit demand;
    bit ped_after;
    demand    = m_ped | ped_req;
    ped_after = demand;
    if (ce) begin
      if (m_left > 1) m_left--;
      else begin
        case (m_ph)
          PH_NSG: if (ew_sense || demand) enter(PH_NSY);
          PH_EWG: if (ns_sense || demand) enter(PH_EWY);
          PH_NSY: begin m_dir_ew = 1'b1; enter(PH_CLR); end
          PH_EWY: begin m_dir_ew = 1'b0; enter(PH_CLR); end
          PH_CLR: begin
            if (demand) begin enter(PH_WALK); ped_after = 1'b0; end
            else enter(m_dir_ew ? PH_EWG : PH_NSG);
          end
          default: enter(m_dir_ew ? PH_EWG : PH_NSG);
        endcase
      end
    end
    m_ped = ped_after;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string name);
    logic [20:0] exp_v;
    logic [6:0]  e_ns, e_ew;
    e_ns  = (m_ph == PH_NSG || m_ph == PH_NSY) ? 7'(m_left) : 7'd0;
    e_ew  = (m_ph == PH_EWG || m_ph == PH_EWY) ? 7'(m_left) : 7'd0;
    exp_v = {lamp_of(m_ph), e_ns, e_ew, (m_ph == PH_WALK)};
    check_val(name, 32'({lights, time_left_ns, time_left_ew, ped_walk}), 32'(exp_v));
  endtask

  int ce_mode = 0;   // 0: ce as driven, 1: one tick in four, 2: random
  int cyc     = 0;

  task automatic step();
    if (ce_mode == 1) ce = (cyc % 4 == 0);
    else if (ce_mode == 2) ce = ($urandom_range(0, 2) != 0);
    cyc++;
    @(posedge clk);
    model_edge();
    #1;
    check_model("model");
  endtask

  // Asserted between edges so the asynchronous path is what clears state.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    check_model("reset");
    rst = 1'b0;
  endtask

  task automatic wait_lights(input logic [5:0] pat, input int bound, input string name);
    int n = 0;
    while (lights !== pat && n < bound) begin step(); n++; end
    check_val(name, 32'(lights), 32'(pat));
  endtask

  task automatic run_len(input logic [5:0] pat, output int n);
    n = 0;
    while (lights === pat && n < 300) begin n++; step(); end
  endtask

  typedef struct {
    logic       ce;
    logic [5:0] gt;
    logic       ns, ew, ped;
    logic [5:0] l;
    logic [6:0] tns, tew;
    logic       w;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int n;
    int seen;
    rst = 1'b0; ce = 1'b0; green_time = 6'd10;
    ns_sense = 1'b0; ew_sense = 1'b0; ped_req = 1'b0;

    // Basic cycle from reset: ALL_RED 1, NS_G 10, NS_Y 3, ALL_RED 1, EW_G.
    for (int i = 0; i < 10; i++)
      tbl[i] = '{1'b1, 6'd10, 1'b1, 1'b1, 1'b0, 6'b001100, 7'(10 - i), 7'd0, 1'b0};
    for (int i = 10; i < 13; i++)
      tbl[i] = '{1'b1, 6'd10, 1'b1, 1'b1, 1'b0, 6'b010100, 7'(13 - i), 7'd0, 1'b0};
    tbl[13] = '{1'b1, 6'd10, 1'b1, 1'b1, 1'b0, 6'b100100, 7'd0, 7'd0, 1'b0};
    tbl[14] = '{1'b1, 6'd10, 1'b1, 1'b1, 1'b0, 6'b100001, 7'd0, 7'd10, 1'b0};

    #1;
    do_reset();
    check_val("reset_lights", 32'(lights), 32'(6'b100100));
    check_val("reset_counts", 32'({time_left_ns, time_left_ew, ped_walk}), 32'd0);

    for (int i = 0; i < 15; i++) begin
      ce = tbl[i].ce; green_time = tbl[i].gt;
      ns_sense = tbl[i].ns; ew_sense = tbl[i].ew; ped_req = tbl[i].ped;
      step();
      check_val($sformatf("tbl[%0d]", i),
                32'({lights, time_left_ns, time_left_ew, ped_walk}),
                32'({tbl[i].l, tbl[i].tns, tbl[i].tew, tbl[i].w}));
    end

    // Min-green floor for green_time 2 and 0.
    for (int k = 0; k < 2; k++) begin
      do_reset();
      ce = 1'b1; ns_sense = 1'b1; ew_sense = 1'b1; ped_req = 1'b0;
      green_time = (k == 0) ? 6'd2 : 6'd0;
      wait_lights(6'b001100, 10, "mingreen_enter");
      run_len(6'b001100, n);
      check_val($sformatf("mingreen_len_gt%0d", green_time), 32'(n), 32'(MG));
    end

    // Rest in green, then one tick of response when EW demand appears.
    do_reset();
    ce = 1'b1; green_time = 6'd5; ns_sense = 1'b1; ew_sense = 1'b0;
    for (int i = 0; i < 40; i++) step();
    check_val("rest_lights", 32'(lights), 32'(6'b001100));
    check_val("rest_tln", 32'(time_left_ns), 32'd1);
    ew_sense = 1'b1;
    step();
    check_val("rest_exit_yellow", 32'({lights, time_left_ns}), 32'({6'b010100, 7'd3}));
    for (int i = 0; i < 4; i++) step();
    check_val("rest_ew_green", 32'({lights, time_left_ew}), 32'({6'b100001, 7'd5}));

    // Pedestrian request mid NS_G, re-press during WALK.
    do_reset();
    ce = 1'b1; green_time = 6'd10; ns_sense = 1'b1; ew_sense = 1'b1;
    for (int i = 0; i < 4; i++) step();
    ped_req = 1'b1; step(); ped_req = 1'b0;
    n = 0;
    while (!ped_walk && n < 60) begin step(); n++; end
    check_val("ped_walk_seen", 32'(ped_walk), 32'd1);
    check_val("ped_walk_lights", 32'(lights), 32'(6'b100100));
    n = 1;
    ped_req = 1'b1; step(); ped_req = 1'b0;
    if (ped_walk) n++;
    while (ped_walk && n < 300) begin step(); if (ped_walk) n++; end
    check_val("ped_walk_len", 32'(n), 32'(WT));
    check_val("ped_after_walk", 32'(lights), 32'(6'b100001));
    wait_lights(6'b100010, 40, "ped_ew_yellow");
    seen = 0;
    for (int i = 0; i < 20; i++) begin step(); if (ped_walk) seen = 1; end
    check_val("ped_second_walk", 32'(seen), 32'd1);

    // ce one tick in four: green of 5 ticks spans 20 clocks; ped on ce=0 latched.
    do_reset();
    ce_mode = 1; green_time = 6'd5; ns_sense = 1'b1; ew_sense = 1'b1;
    wait_lights(6'b001100, 20, "cediv_enter");
    run_len(6'b001100, n);
    check_val("cediv_green_span", 32'(n), 32'd20);
    while (cyc % 4 == 0) step();
    ped_req = 1'b1; step(); ped_req = 1'b0;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin step(); if (ped_walk) seen = 1; end
    check_val("cediv_ped_latched", 32'(seen), 32'd1);
    ce_mode = 0;

    // Asynchronous reset mid EW_Y drops a latched pedestrian request.
    do_reset();
    ce = 1'b1; green_time = 6'd4; ns_sense = 1'b1; ew_sense = 1'b1;
    wait_lights(6'b100010, 60, "arst_ew_yellow");
    ped_req = 1'b1; step(); ped_req = 1'b0;
    check_val("arst_still_yellow", 32'(lights), 32'(6'b100010));
    rst = 1'b1;
    #1;
    check_val("arst_lights", 32'(lights), 32'(6'b100100));
    check_val("arst_counts", 32'({time_left_ns, time_left_ew, ped_walk}), 32'd0);
    do_reset();
    seen = 0;
    for (int i = 0; i < 40; i++) begin step(); if (ped_walk) seen = 1; end
    check_val("arst_no_walk", 32'(seen), 32'd0);

    // Randomized traffic against the model, with the safety invariant.
    ce_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) green_time = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 19) == 0) ns_sense = ~ns_sense;
      if ($urandom_range(0, 19) == 0) ew_sense = ~ew_sense;
      ped_req = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      step();
      check_val("safety",
                32'(((lights[5] + lights[4] + lights[3]) == 2'd1) &&
                    ((lights[2] + lights[1] + lights[0]) == 2'd1) &&
                    !((lights[4] | lights[3]) && (lights[1] | lights[0]))),
                32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
